ram_reader: RTL and testbench

Readback stage that sits directly downstream of the RAM filled by the write controller. When the controller signals completion, it scans every RAM location in ascending address order through a synchronous read port and streams the bytes out over a valid/ready interface. It also accumulates a modulo-2^DATA_W checksum of all bytes delivered. A two-entry output buffer absorbs the one-cycle RAM read latency, so the stream sustains one byte per cycle under full throughput and tolerates arbitrary backpressure.

---
 rtl/ram_reader.sv | 159 +++++++++++++++
 tb/tb_ram_reader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_reader.sv
`default_nettype none
// ============================================================================
//  Module   : ram_reader
//  Purpose  : Scans RAM addresses 0..DEPTH-1 through a synchronous read port
//             and streams the bytes out on a valid/ready interface. A
//             two-entry buffer absorbs the one-cycle read latency. Also keeps
//             a running modulo-2^DATA_W checksum of the delivered bytes.
//  Revision : 1.0  initial release
// ============================================================================
module ram_reader #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_add,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [DATA_W-1:0] checksum,
  output logic              scan_done,
  output logic              busy
);

  // Counters carry one extra bit so they can represent DEPTH itself.
  localparam int              c_CW    = ADDR_W + 1;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_LAST  = c_CW'(DEPTH - 1);
  localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [c_CW-1:0]   r_rd_cnt;
  logic [c_CW-1:0]   r_xfer_cnt;
  logic [DATA_W-1:0] r_checksum;
  logic              r_scan_done;
  logic              r_busy;

  // Two-entry output buffer plus the "data returns this cycle" flag.
  logic [DATA_W-1:0] r_mem [0:1];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              r_pend;

  logic              w_pop;
  logic              w_issue;
  logic [2:0]        w_credit;

  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_mem[r_rd_ptr];
  // Bytes leave strictly in address order, so the head is the last byte
  // exactly when DEPTH-1 bytes have already been transferred.
  assign out_last  = out_valid && (r_xfer_cnt == c_LAST);
  assign checksum  = r_checksum;
  assign scan_done = r_scan_done;
  assign busy      = r_busy;
  assign rd_add    = r_rd_cnt[ADDR_W-1:0];

  assign w_pop    = out_valid && out_ready;
  // Buffered bytes plus the read whose data is on rd_data right now.
  assign w_credit = {1'b0, r_count} + {2'b00, r_pend};
  // The strobe is decided in the same cycle as the pop so that a byte leaving
  // the buffer frees its slot immediately; this is what sustains one byte per
  // cycle with only two entries while still never overflowing under stalls.
  assign w_issue  = (r_state == S_SCAN) && (r_rd_cnt < c_DEPTH) &&
                    (w_credit < (3'd2 + {2'b00, w_pop}));
  assign rd_en    = w_issue;

  // Control FSM: scan sequencing, transfer counting and checksum accumulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_rd_cnt    <= '0;
      r_xfer_cnt  <= '0;
      r_checksum  <= '0;
      r_scan_done <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_pop) begin
        r_checksum <= r_checksum + out_data;
        r_xfer_cnt <= r_xfer_cnt + c_ONE;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_SCAN;
            r_busy     <= 1'b1;
            r_rd_cnt   <= '0;
            r_xfer_cnt <= '0;
            r_checksum <= '0;
          end
        end
        S_SCAN: begin
          if (w_issue) begin
            r_rd_cnt <= r_rd_cnt + c_ONE;
            if (r_rd_cnt == c_LAST) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_pop && out_last) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_scan_done <= 1'b1;
          end
        end
        S_DONE: begin
          // Hold here until start drops so a level start cannot retrigger.
          if (!start) begin
            r_state     <= S_IDLE;
            r_scan_done <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output buffer: capture returning read data, advance head on transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_pend   <= 1'b0;
    end else begin
      r_pend <= w_issue;
      if (r_pend) begin
        r_mem[r_wr_ptr] <= rd_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({r_pend, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_reader
//  Purpose  : Self-checking bench for ram_reader: per-cycle vector table for
//             the unstalled scan, plus directed sequences for backpressure,
//             checksum wrap, mid-scan reset and level-start handling.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_reader;

  logic       clk;
  logic       rst;
  logic       start;
  logic       out_ready;
  logic       rd_en;
  logic [2:0] rd_add;
  logic [7:0] rd_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic [7:0] checksum;
  logic       scan_done;
  logic       busy;

  ram_reader #(.ADDR_W(3), .DATA_W(8), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rd_en     (rd_en),
    .rd_add    (rd_add),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .checksum  (checksum),
    .scan_done (scan_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM model; rd_data may be overridden with noise.
  logic [7:0] ram [8];
  logic [7:0] rd_q;
  logic       rnd_mode;
  logic [7:0] rnd_byte;
  always @(posedge clk) if (rd_en) rd_q <= ram[rd_add];
  assign rd_data = rnd_mode ? rnd_byte : rd_q;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Stream monitor state
  bit         mon_en = 1'b0;
  int         n_iss;
  int         n_xf;
  bit         hold;
  logic [7:0] hold_data;
  logic       hold_last;

  task automatic mon_start();
    n_iss  = 0;
    n_xf   = 0;
    hold   = 1'b0;
    mon_en = 1'b1;
  endtask

  // Wait for the falling edge and run stream checks for this cycle.
  task automatic at_neg();
    @(negedge clk);
    if (mon_en) begin
      chk("outstanding_le2", ((n_iss - n_xf) <= 2), 1);
      if (hold) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, hold_data);
        chk("stall_last", out_last, hold_last);
      end
      if (rd_en) begin
        chk("rd_in_range", (n_iss < 8), 1);
        chk("rd_add_order", rd_add, n_iss[2:0]);
        n_iss++;
      end
      if (out_valid && out_ready) begin
        chk("xfer_in_range", (n_xf < 8), 1);
        if (n_xf < 8) chk("xfer_data", out_data, ram[n_xf]);
        chk("xfer_last", out_last, (n_xf == 7));
        n_xf++;
      end
      hold      = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
    end
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_scan(input bit rnd, input bit hold_start, input logic [7:0] want_sum);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      at_neg();
      if (scan_done) begin
        seen = 1'b1;
        break;
      end
      to_next();
      if (!hold_start) start = 1'b0;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    chk("scan_done_seen", seen, 1);
    chk("byte_count", n_xf, 8);
    chk("final_checksum", checksum, want_sum);
    mon_en = 1'b0;
    to_next();
    out_ready = 1'b1;
    if (!hold_start) start = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_add"}, rd_add, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_checksum"}, checksum, 0);
    chk({tag, "_scan_done"}, scan_done, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  typedef struct {
    logic       st;
    logic       rdy;
    logic       en;
    logic [2:0] add;
    logic       val;
    logic [7:0] data;
    logic       last;
    logic       done;
    logic       bsy;
    logic [7:0] csum;
  } vec_t;

  vec_t tbl [13];

  initial begin
    rst = 1'b0; start = 1'b0; out_ready = 1'b0;
    rnd_mode = 1'b1; rnd_byte = 8'h00;
    for (int i = 0; i < 8; i++) ram[i] = 8'(i + 1);

    // Unstalled scan of 01..08, start pulsed in cycle 0.
    //           st    rdy   en    add   val   data   last  done  bsy   csum
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h01};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 8'h03};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 3'd5, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h06};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 3'd6, 1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h0A};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 3'd7, 1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 8'h0F};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 8'h15};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 8'h08, 1'b1, 1'b0, 1'b1, 8'h1C};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h24};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h24};

    // Reset held with random inputs.
    to_next();
    for (int i = 0; i < 5; i++) begin
      start     = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      rnd_byte  = 8'($urandom_range(0, 255));
      at_neg();
      chk_reset_outs("in_reset");
      to_next();
    end
    rnd_mode = 1'b0; start = 1'b0; out_ready = 1'b1; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("idle_rd_en", rd_en, 0);
      chk("idle_busy", busy, 0);
      to_next();
    end

    // Table-driven unstalled scan.
    for (int i = 0; i < 13; i++) begin
      start     = tbl[i].st;
      out_ready = tbl[i].rdy;
      at_neg();
      chk($sformatf("c%0d_rd_en", i), rd_en, tbl[i].en);
      if (tbl[i].en) chk($sformatf("c%0d_rd_add", i), rd_add, tbl[i].add);
      chk($sformatf("c%0d_out_valid", i), out_valid, tbl[i].val);
      if (tbl[i].val) chk($sformatf("c%0d_out_data", i), out_data, tbl[i].data);
      chk($sformatf("c%0d_out_last", i), out_last, tbl[i].last);
      chk($sformatf("c%0d_scan_done", i), scan_done, tbl[i].done);
      chk($sformatf("c%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("c%0d_checksum", i), checksum, tbl[i].csum);
      to_next();
    end

    // Random backpressure.
    mon_start();
    start = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    wait_scan(1'b1, 1'b0, 8'h24);

    // All 0xFF: checksum wraps to 0xF8.
    for (int i = 0; i < 8; i++) ram[i] = 8'hFF;
    mon_start();
    start = 1'b1;
    wait_scan(1'b0, 1'b0, 8'hF8);
    for (int i = 0; i < 8; i++) ram[i] = 8'(i + 1);

    // Reset after three transfers with a read in flight.
    mon_start();
    start = 1'b1;
    for (int c = 0; c < 50; c++) begin
      at_neg();
      if (n_xf >= 3) break;
      to_next();
      start = 1'b0;
    end
    chk("pre_reset_xfers", n_xf, 3);
    to_next();
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    chk_reset_outs("mid_reset");
    to_next();
    to_next();
    rst = 1'b1;
    mon_start();
    start = 1'b1;
    wait_scan(1'b0, 1'b0, 8'h24);

    // Start held high after completion, then dropped for one cycle.
    mon_start();
    start = 1'b1;
    wait_scan(1'b0, 1'b1, 8'h24);
    for (int i = 0; i < 10; i++) begin
      at_neg();
      chk("held_scan_done", scan_done, 1);
      chk("held_no_rd_en", rd_en, 0);
      chk("held_busy", busy, 0);
      to_next();
    end
    start = 1'b0;
    at_neg();
    to_next();
    start = 1'b1;
    at_neg();
    chk("rearm_scan_done_clr", scan_done, 0);
    chk("rearm_busy", busy, 0);
    chk("rearm_checksum_held", checksum, 8'h24);
    mon_start();
    to_next();
    at_neg();
    chk("rescan_busy", busy, 1);
    chk("rescan_checksum_clr", checksum, 0);
    to_next();
    wait_scan(1'b0, 1'b0, 8'h24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
